// File: rtl/crack_ctrl.sv
// crack_ctrl: key-search scheduler for ARC4 ciphertext cracking.
// Drives one arc4 core with successive candidate keys and scans each
// decrypted message for printable ASCII (0x20..0x7E). It stops on the first
// passing key, when the key range runs out, or when stop is raised.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   en / rdy       start request (sampled only while rdy=1) / idle indicator
//   stop           level, abort the search at the next safe point
//   key            current candidate; holds the found key in DONE
//   key_valid      in DONE: 1 = key found, 0 = exhausted or stopped
//   arc4_en        one-cycle start pulse to arc4
//   arc4_rdy       arc4 ready
//   scan_active    controller owns the plaintext read port
//   pt_addr        plaintext read address
//   pt_rddata      plaintext read data, valid one cycle after pt_addr
module crack_ctrl #(
   parameter logic [23:0] KEY_START = 24'h000000,
   parameter logic [7:0]  KEY_STEP  = 8'd1,
   parameter logic [23:0] KEY_LAST  = 24'hFFFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic        rdy,
   input  logic        stop,
   output logic [23:0] key,
   output logic        key_valid,
   output logic        arc4_en,
   input  logic        arc4_rdy,
   output logic        scan_active,
   output logic [7:0]  pt_addr,
   input  logic [7:0]  pt_rddata
);

   localparam int unsigned KEY_W  = 24;
   localparam int unsigned SUM_W  = 25;
   localparam int unsigned ADDR_W = 8;
   localparam logic [7:0]  CHAR_LO = 8'h20;
   localparam logic [7:0]  CHAR_HI = 8'h7E;

   typedef enum logic [3:0] {
      S_IDLE,
      S_START,
      S_WAIT_LO,
      S_WAIT_HI,
      S_RD_LEN,
      S_LEN_WAIT,
      S_SCAN,
      S_NEXT,
      S_DONE
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [KEY_W-1:0]    r_key, w_key_nxt;
   logic                r_key_valid, w_key_valid_nxt;
   logic                r_rdy, w_rdy_nxt;
   logic                r_arc4_en, w_arc4_en_nxt;
   logic                r_scan_active, w_scan_active_nxt;
   logic [ADDR_W-1:0]   r_pt_addr, w_pt_addr_nxt;
   logic [ADDR_W-1:0]   r_len, w_len_nxt;
   logic [ADDR_W-1:0]   r_chk_addr, w_chk_addr_nxt;
   logic                r_chk_vld, w_chk_vld_nxt;
   logic                r_stop_pend, w_stop_pend_nxt;

   logic [SUM_W-1:0]    w_key_sum;
   logic                w_exhausted;
   logic                w_byte_ok;
   logic                w_last_byte;

   // Next candidate in 25 bits so a carry out is seen instead of wrapping to 0
   assign w_key_sum   = {1'b0, r_key} + SUM_W'(KEY_STEP);
   assign w_exhausted = w_key_sum[SUM_W-1] || (w_key_sum > {1'b0, KEY_LAST});

   // Printable check on the byte returned for the address issued last cycle
   assign w_byte_ok   = (pt_rddata >= CHAR_LO) && (pt_rddata <= CHAR_HI);
   assign w_last_byte = (r_chk_addr == r_len);

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_key         <= KEY_START;
         r_key_valid   <= 1'b0;
         r_rdy         <= 1'b1;
         r_arc4_en     <= 1'b0;
         r_scan_active <= 1'b0;
         r_pt_addr     <= '0;
         r_len         <= '0;
         r_chk_addr    <= '0;
         r_chk_vld     <= 1'b0;
         r_stop_pend   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_key         <= w_key_nxt;
         r_key_valid   <= w_key_valid_nxt;
         r_rdy         <= w_rdy_nxt;
         r_arc4_en     <= w_arc4_en_nxt;
         r_scan_active <= w_scan_active_nxt;
         r_pt_addr     <= w_pt_addr_nxt;
         r_len         <= w_len_nxt;
         r_chk_addr    <= w_chk_addr_nxt;
         r_chk_vld     <= w_chk_vld_nxt;
         r_stop_pend   <= w_stop_pend_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt     = r_state;
      w_key_nxt       = r_key;
      w_key_valid_nxt = r_key_valid;
      w_pt_addr_nxt   = r_pt_addr;
      w_len_nxt       = r_len;
      w_chk_addr_nxt  = r_chk_addr;
      w_chk_vld_nxt   = 1'b0;
      w_stop_pend_nxt = r_stop_pend;
      w_arc4_en_nxt   = 1'b0;

      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (en) begin
               w_state_nxt     = S_START;
               w_key_nxt       = KEY_START;
               w_key_valid_nxt = 1'b0;
               w_stop_pend_nxt = 1'b0;
            end
         end

         S_START: begin
            if (stop) begin
               w_state_nxt     = S_DONE;
               w_key_valid_nxt = 1'b0;
            end else if (arc4_rdy) begin
               w_state_nxt   = S_WAIT_LO;
               w_arc4_en_nxt = 1'b1;
            end
         end

         // arc4 drops rdy one cycle after en; a stop seen here is held
         // until arc4 has finished the current key
         S_WAIT_LO: begin
            if (stop) begin
               w_stop_pend_nxt = 1'b1;
            end
            if (!arc4_rdy) begin
               w_state_nxt = S_WAIT_HI;
            end
         end

         S_WAIT_HI: begin
            if (arc4_rdy) begin
               w_pt_addr_nxt = '0;
               if (stop || r_stop_pend) begin
                  w_state_nxt     = S_DONE;
                  w_key_valid_nxt = 1'b0;
               end else begin
                  w_state_nxt = S_RD_LEN;
               end
            end
         end

         S_RD_LEN: begin
            if (stop) begin
               w_state_nxt     = S_DONE;
               w_key_valid_nxt = 1'b0;
            end else begin
               w_state_nxt = S_LEN_WAIT;
            end
         end

         // Empty message counts as a find and wins over stop
         S_LEN_WAIT: begin
            w_len_nxt = pt_rddata;
            if (pt_rddata == '0) begin
               w_state_nxt     = S_DONE;
               w_key_valid_nxt = 1'b1;
            end else if (stop) begin
               w_state_nxt     = S_DONE;
               w_key_valid_nxt = 1'b0;
            end else begin
               w_pt_addr_nxt = ADDR_W'(1);
               w_state_nxt   = S_SCAN;
            end
         end

         // Address issue and byte check overlap; address stops at L (no wrap)
         S_SCAN: begin
            w_chk_addr_nxt = r_pt_addr;
            w_chk_vld_nxt  = 1'b1;
            if (r_pt_addr != r_len) begin
               w_pt_addr_nxt = r_pt_addr + ADDR_W'(1);
            end
            if (r_chk_vld && w_byte_ok && w_last_byte) begin
               w_state_nxt     = S_DONE;
               w_key_valid_nxt = 1'b1;
            end else if (stop) begin
               w_state_nxt     = S_DONE;
               w_key_valid_nxt = 1'b0;
            end else if (r_chk_vld && !w_byte_ok) begin
               w_state_nxt = S_NEXT;
            end
         end

         S_NEXT: begin
            if (stop || w_exhausted) begin
               w_state_nxt     = S_DONE;
               w_key_valid_nxt = 1'b0;
            end else begin
               w_key_nxt   = w_key_sum[KEY_W-1:0];
               w_state_nxt = S_START;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Status outputs follow the state being entered
      w_rdy_nxt         = (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE);
      w_scan_active_nxt = (w_state_nxt == S_RD_LEN) || (w_state_nxt == S_LEN_WAIT) ||
                          (w_state_nxt == S_SCAN);
   end

   assign rdy         = r_rdy;
   assign key         = r_key;
   assign key_valid   = r_key_valid;
   assign arc4_en     = r_arc4_en;
   assign scan_active = r_scan_active;
   assign pt_addr     = r_pt_addr;

endmodule

// File: tb/tb_crack_ctrl.sv
// tb_crack_ctrl: scoreboard bench for crack_ctrl. Three instances with
// different key ranges, each with a behavioural arc4 + plaintext RAM model.
module tb_crack_ctrl;

   localparam int unsigned N_INST = 3;
   localparam int unsigned TMO    = 5000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N_INST-1:0] en_v   = '0;
   logic [N_INST-1:0] stop_v = '0;

   logic              rdy_a    [N_INST];
   logic [23:0]       key_a    [N_INST];
   logic              kv_a     [N_INST];
   logic              a4en_a   [N_INST];
   logic              scan_a   [N_INST];
   logic [7:0]        addr_a   [N_INST];
   logic              a4rdy_a  [N_INST];
   int unsigned       encnt_a  [N_INST];
   int unsigned       viol_a   [N_INST];

   // Plaintext scenario shared by all arc4 models
   logic [7:0]  sc_len      = 8'd5;
   logic [23:0] sc_good     = 24'h000018;
   logic [7:0]  sc_bad_addr = 8'd1;
   logic [7:0]  sc_bad_val  = 8'h1F;
   int unsigned sc_lat      = 6;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   function automatic logic [7:0] mem_byte(input logic [23:0] k, input logic [7:0] a);
      if (a == 8'd0) return sc_len;
      if (k == sc_good) begin
         if (a == 8'd1) return 8'h20;
         if (a == 8'd2) return 8'h7E;
         return 8'h41;
      end
      if (a == sc_bad_addr) return sc_bad_val;
      return 8'h41;
   endfunction

   for (genvar g = 0; g < N_INST; g++) begin : g_inst
      localparam logic [23:0] P_START = (g == 0) ? 24'h000000 : (g == 1) ? 24'h000001 : 24'hFFFFFB;
      localparam logic [7:0]  P_STEP  = (g == 0) ? 8'd1 : (g == 1) ? 8'd2 : 8'd3;
      localparam logic [23:0] P_LAST  = (g == 1) ? 24'h000021 : 24'hFFFFFF;

      logic        rdy, kv, a4en, scan, a4rdy, a4en_q;
      logic [23:0] key, m_key;
      logic [7:0]  addr, rddata;
      int unsigned m_cnt;
      int unsigned en_cnt = 0;
      int unsigned viol   = 0;

      crack_ctrl #(
         .KEY_START (P_START),
         .KEY_STEP  (P_STEP),
         .KEY_LAST  (P_LAST)
      ) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .en          (en_v[g]),
         .rdy         (rdy),
         .stop        (stop_v[g]),
         .key         (key),
         .key_valid   (kv),
         .arc4_en     (a4en),
         .arc4_rdy    (a4rdy),
         .scan_active (scan),
         .pt_addr     (addr),
         .pt_rddata   (rddata)
      );

      // arc4 model: rdy drops the cycle after en, returns after sc_lat+1 cycles
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            a4rdy <= 1'b1;
            m_cnt <= 0;
            m_key <= '0;
         end else if (a4en && a4rdy) begin
            a4rdy <= 1'b0;
            m_key <= key;
            m_cnt <= sc_lat;
         end else if (!a4rdy) begin
            if (m_cnt == 0) a4rdy <= 1'b1;
            else m_cnt <= m_cnt - 1;
         end
      end

      always_ff @(posedge clk) rddata <= mem_byte(m_key, addr);

      // Protocol watch: en only while arc4 ready, single-cycle, no scan while busy
      always @(posedge clk) begin
         if (rst_n) begin
            if (a4en) en_cnt <= en_cnt + 1;
            if ((a4en && (!a4rdy || a4en_q)) || (scan && !a4rdy)) viol <= viol + 1;
         end
         a4en_q <= a4en;
      end

      assign rdy_a[g]   = rdy;
      assign key_a[g]   = key;
      assign kv_a[g]    = kv;
      assign a4en_a[g]  = a4en;
      assign scan_a[g]  = scan;
      assign addr_a[g]  = addr;
      assign a4rdy_a[g] = a4rdy;
      assign encnt_a[g] = en_cnt;
      assign viol_a[g]  = viol;
   end

   // Scoreboard: expected result pushed at start, popped when rdy rises
   typedef struct {
      int unsigned inst;
      logic [23:0] key;
      logic        kv;
   } exp_t;

   exp_t exp_q[$];
   logic rdy_q [N_INST] = '{default: 1'b1};

   always @(negedge clk) begin
      exp_t e;
      for (int g = 0; g < N_INST; g++) begin
         if (rdy_a[g] && !rdy_q[g]) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL done_unexpected inst=%0d actual key=%h valid=%0b required no completion",
                        g, key_a[g], kv_a[g]);
            end else begin
               e = exp_q.pop_front();
               if (e.inst != g || key_a[g] != e.key || kv_a[g] != e.kv) begin
                  n_err++;
                  $display("FAIL result inst=%0d actual key=%h valid=%0b required inst=%0d key=%h valid=%0b",
                           g, key_a[g], kv_a[g], e.inst, e.key, e.kv);
               end
            end
         end
         rdy_q[g] = rdy_a[g];
      end
   end

   // Scan window lengths and address ordering on instance 0
   int unsigned scan_run = 0;
   int unsigned scan_lens[$];
   logic [7:0]  addr_prev = '0;
   logic [7:0]  addr_max  = '0;
   int unsigned addr_order_err = 0;

   always @(negedge clk) begin
      if (scan_a[0]) begin
         if (scan_run != 0 && addr_a[0] != addr_prev && addr_a[0] != addr_prev + 8'd1)
            addr_order_err++;
         if (addr_a[0] > addr_max) addr_max = addr_a[0];
         addr_prev = addr_a[0];
         scan_run++;
      end else if (scan_run != 0) begin
         scan_lens.push_back(scan_run);
         scan_run = 0;
      end
   end

   task automatic tick(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input longint unsigned act, input longint unsigned req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic start(input int g, input logic [23:0] k, input logic kv);
      exp_t e;
      e.inst = g;
      e.key  = k;
      e.kv   = kv;
      exp_q.push_back(e);
      en_v[g] = 1'b1;
      @(negedge clk);
      en_v[g] = 1'b0;
   endtask

   task automatic wait_done(input int g, input string name);
      int unsigned n = 0;
      while (!rdy_a[g] && n < TMO) begin
         @(negedge clk);
         n++;
      end
      check(name, longint'(rdy_a[g]), 1);
   endtask

   function automatic int unsigned scan_len(input int unsigned i);
      if (scan_lens.size() > i) return scan_lens[i];
      return 0;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned c, n;

      // Reset values
      tick(2);
      check("rst_rdy",       longint'(rdy_a[0]),  1);
      check("rst_key",       longint'(key_a[0]),  0);
      check("rst_key_valid", longint'(kv_a[0]),   0);
      check("rst_arc4_en",   longint'(a4en_a[0]), 0);
      check("rst_scan",      longint'(scan_a[0]), 0);
      check("rst_pt_addr",   longint'(addr_a[0]), 0);
      check("rst_key_inst2", longint'(key_a[2]),  24'hFFFFFB);
      rst_n = 1'b1;
      tick(2);

      // Sweep 0..0x18, wrong keys fail at addr 1 with 0x1F; en while busy ignored
      c = encnt_a[0];
      scan_lens.delete();
      start(0, 24'h000018, 1'b1);
      tick(30);
      en_v[0] = 1'b1;
      tick(1);
      en_v[0] = 1'b0;
      check("busy_rdy", longint'(rdy_a[0]), 0);
      wait_done(0, "sweep_done");
      tick(2);
      check("sweep_en_pulses", encnt_a[0] - c, 25);
      check("sweep_fail_window", scan_len(0), 4);
      check("sweep_pass_window", scan_len(24), 8);
      check("sweep_key_hold", longint'(key_a[0]), 24'h000018);
      check("sweep_valid_hold", longint'(kv_a[0]), 1);

      // Odd keys only up to KEY_LAST=0x21; 0x18 never tried
      sc_bad_addr = 8'd2;
      sc_bad_val  = 8'h7F;
      c = encnt_a[1];
      start(1, 24'h000021, 1'b0);
      wait_done(1, "stride_done");
      tick(2);
      check("stride_en_pulses", encnt_a[1] - c, 17);

      // Top of the 24-bit range: carry out ends the search, no wrap
      c = encnt_a[2];
      start(2, 24'hFFFFFE, 1'b0);
      wait_done(2, "carry_done");
      tick(2);
      check("carry_en_pulses", encnt_a[2] - c, 2);

      // Empty message on first key
      sc_len = 8'd0;
      sc_good = 24'h000000;
      c = encnt_a[0];
      scan_lens.delete();
      start(0, 24'h000000, 1'b1);
      wait_done(0, "len0_done");
      tick(2);
      check("len0_window", scan_len(0), 2);
      check("len0_en_pulses", encnt_a[0] - c, 1);

      // 255-byte message read in order, one address per cycle
      sc_len = 8'd255;
      scan_lens.delete();
      addr_max = '0;
      addr_order_err = 0;
      start(0, 24'h000000, 1'b1);
      wait_done(0, "len255_done");
      tick(2);
      check("len255_window", scan_len(0), 258);
      check("len255_addr_max", addr_max, 255);
      check("len255_addr_order", addr_order_err, 0);

      // 0x7F at address 3 of a 10-byte message for key 0; key 1 passes
      sc_len = 8'd10;
      sc_good = 24'h000001;
      sc_bad_addr = 8'd3;
      sc_bad_val = 8'h7F;
      c = encnt_a[0];
      scan_lens.delete();
      start(0, 24'h000001, 1'b1);
      n = 0;
      while (!scan_a[0] && n < TMO) begin @(negedge clk); n++; end
      while (scan_a[0] && n < TMO) begin @(negedge clk); n++; end
      n = 0;
      while (!a4en_a[0] && n < 20) begin @(negedge clk); n++; end
      check("bad7f_next_en_gap", n, 2);
      check("bad7f_next_key", longint'(key_a[0]), 24'h000001);
      wait_done(0, "bad7f_done");
      tick(2);
      check("bad7f_fail_window", scan_len(0), 6);
      check("bad7f_pass_window", scan_len(1), 13);
      check("bad7f_en_pulses", encnt_a[0] - c, 2);

      // stop in WAIT_HI: finish arc4, then DONE without another arc4_en
      sc_lat = 20;
      sc_len = 8'd5;
      sc_good = 24'h000018;
      sc_bad_addr = 8'd1;
      sc_bad_val = 8'h1F;
      c = encnt_a[0];
      start(0, 24'h000000, 1'b0);
      n = 0;
      while (a4rdy_a[0] && n < TMO) begin @(negedge clk); n++; end
      tick(3);
      stop_v[0] = 1'b1;
      tick(1);
      check("stophi_hold", longint'(rdy_a[0]), 0);
      n = 0;
      while (!a4rdy_a[0] && n < TMO) begin @(negedge clk); n++; end
      check("stophi_arc4_back", longint'(rdy_a[0]), 0);
      tick(1);
      check("stophi_rdy", longint'(rdy_a[0]), 1);
      check("stophi_valid", longint'(kv_a[0]), 0);
      stop_v[0] = 1'b0;
      tick(3);
      check("stophi_en_pulses", encnt_a[0] - c, 1);
      sc_lat = 6;

      // stop in SCAN: DONE on the next cycle
      sc_len = 8'd200;
      sc_good = 24'h000000;
      start(0, 24'h000000, 1'b0);
      n = 0;
      while (!scan_a[0] && n < TMO) begin @(negedge clk); n++; end
      tick(3);
      stop_v[0] = 1'b1;
      tick(1);
      check("stopscan_rdy", longint'(rdy_a[0]), 1);
      check("stopscan_valid", longint'(kv_a[0]), 0);
      check("stopscan_scan", longint'(scan_a[0]), 0);
      stop_v[0] = 1'b0;
      tick(2);

      // Reset during SCAN of key 3
      sc_good = 24'h000003;
      start(0, 24'h000000, 1'b0);
      n = 0;
      while (!(key_a[0] == 24'h000003 && scan_a[0]) && n < TMO) begin @(negedge clk); n++; end
      en_v[0] = 1'b1;
      tick(1);
      en_v[0] = 1'b0;
      tick(4);
      check("rstmid_key_before", longint'(key_a[0]), 24'h000003);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_rdy",       longint'(rdy_a[0]),  1);
      check("rstmid_key",       longint'(key_a[0]),  0);
      check("rstmid_key_valid", longint'(kv_a[0]),   0);
      check("rstmid_arc4_en",   longint'(a4en_a[0]), 0);
      check("rstmid_scan",      longint'(scan_a[0]), 0);
      check("rstmid_pt_addr",   longint'(addr_a[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(2);

      // Restart after reset begins from KEY_START
      sc_len = 8'd3;
      sc_good = 24'h000002;
      c = encnt_a[0];
      start(0, 24'h000002, 1'b1);
      wait_done(0, "restart_done");
      tick(2);
      check("restart_en_pulses", encnt_a[0] - c, 3);

      check("scoreboard_empty", exp_q.size(), 0);
      for (int g = 0; g < N_INST; g++) check("arc4_protocol", viol_a[g], 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
